rr_resp_router: RTL

- Return-path companion to the round-robin request arbitration tree.
- Records the index of each request granted at the tree root in an in-order tracking FIFO.
- When the slave returns an in-order response, delivers it to the originating master one cycle later.
- Flags full, overflow and spurious responses so the request side can throttle grants.

---
 rtl/rr_resp_router.sv | 98 +++++++++
 1 files changed

// File: rtl/rr_resp_router.sv
// Return-path router: remembers which master each root grant belonged to and
// steers the in-order slave response back to that master one cycle later.
module rr_resp_router #(
    parameter int NumOut         = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4,
    localparam int IdxWidth      = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [IdxWidth-1:0]  push_idx_i,
    input  logic                 resp_valid_i,
    input  logic [DataWidth-1:0] resp_data_i,
    output logic [NumOut-1:0]    resp_valid_o,
    output logic [DataWidth-1:0] resp_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntWidth-1:0]  count_o,
    output logic                 overflow_o,
    output logic                 spurious_o
);

    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

    // Handshake: push_i and resp_valid_i are single-cycle strobes with no
    // ready; a push is only taken when a slot is free (or freed the same
    // cycle), and a response is only routed when something is outstanding.

    logic [IdxWidth-1:0] idx_mem [MaxOutstanding];
    logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                full, empty, pop, push_acc, head_ok;
    logic [IdxWidth-1:0] head_idx;
    logic [NumOut-1:0]   valid_d;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == FullCnt);
    assign empty    = (count_q == '0);
    assign pop      = resp_valid_i & ~empty;
    assign push_acc = push_i & (~full | pop);
    assign head_idx = idx_mem[rd_ptr_q];

    assign full_o   = full;
    assign empty_o  = empty;
    assign count_o  = count_q;

    generate
        if (NumOut == 1) begin : g_single
            assign head_ok = 1'b1;
            assign valid_d = pop;
        end else begin : g_multi
            localparam logic [IdxWidth:0] NumOutW = (IdxWidth + 1)'(NumOut);
            // Indices beyond the last master can only appear for
            // non-power-of-2 NumOut; they are reported, not delivered.
            assign head_ok = ({1'b0, head_idx} < NumOutW);
            always_comb begin
                valid_d = '0;
                for (int i = 0; i < NumOut; i++) begin
                    valid_d[i] = pop && (head_idx == IdxWidth'(i));
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            idx_mem[wr_ptr_q] <= push_idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_o <= '0;
            resp_data_o  <= '0;
            overflow_o   <= 1'b0;
            spurious_o   <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q      <= count_q + CntWidth'(push_acc) - CntWidth'(pop);
            resp_valid_o <= valid_d;
            if (pop) resp_data_o <= resp_data_i;
            overflow_o   <= push_i & ~push_acc;
            spurious_o   <= (resp_valid_i & empty) | (pop & ~head_ok);
        end
    end

endmodule
